// File: rtl/cond_pkg.sv
// Shared constants for the ARM condition-evaluation unit: condition codes
// and NZCV flag bit positions.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_decode.sv
// Combinational decode of one 4-bit ARM condition field against NZCV flags.
module cond_decode
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    input  logic       nv_mode,
    output logic       ok
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        ok = 1'b0;
        unique case (cond)
            COND_EQ: ok = z;
            COND_NE: ok = !z;
            COND_CS: ok = c;
            COND_CC: ok = !c;
            COND_MI: ok = n;
            COND_PL: ok = !n;
            COND_VS: ok = v;
            COND_VC: ok = !v;
            COND_HI: ok = c & !z;
            COND_LS: ok = !c | z;
            COND_GE: ok = (n == v);
            COND_LT: ok = (n != v);
            COND_GT: ok = !z & (n == v);
            COND_LE: ok = z | (n != v);
            COND_AL: ok = 1'b1;
            COND_NV: ok = nv_mode;
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_eval_unit.sv
// Multi-channel condition-evaluation stage: NZCV flag register, optional
// same-cycle flag bypass, and a registered pass/fail output with stall/flush.
module cond_eval_unit
    import cond_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int BYPASS  = 1,
    parameter int NV_MODE = 0
)
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  FLAG_WE,
    input  logic [3:0]            FLAG_IN,
    input  logic                  IN_VALID,
    input  logic [4*NUM_CH-1:0]   COND,
    input  logic                  HOLD,
    input  logic                  FLUSH,
    output logic                  OUT_VALID,
    output logic [NUM_CH-1:0]     COND_OK,
    output logic [3:0]            FLAGS
);

    localparam logic USE_BYPASS = (BYPASS != 0);
    localparam logic NV_BIT     = (NV_MODE != 0);

    logic [3:0]        flags_q, flags_d;
    logic [3:0]        eff_flags;
    logic              out_valid_q, out_valid_d;
    logic [NUM_CH-1:0] cond_ok_q, cond_ok_d;
    logic [NUM_CH-1:0] ch_ok;

    // Flag register writes ignore HOLD/FLUSH: an S-bit result is architectural.
    always_comb begin
        flags_d = flags_q;
        if (FLAG_WE) begin
            flags_d = FLAG_IN;
        end
    end

    assign eff_flags = (USE_BYPASS && FLAG_WE) ? FLAG_IN : flags_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cond_decode u_decode (
            .cond    (COND[4*i +: 4]),
            .flags   (eff_flags),
            .nv_mode (NV_BIT),
            .ok      (ch_ok[i])
        );
    end

    // Output stage: FLUSH beats HOLD; gating with IN_VALID keeps COND_OK clean.
    always_comb begin
        out_valid_d = out_valid_q;
        cond_ok_d   = cond_ok_q;
        if (FLUSH) begin
            out_valid_d = 1'b0;
            cond_ok_d   = '0;
        end else if (!HOLD) begin
            out_valid_d = IN_VALID;
            cond_ok_d   = ch_ok & {NUM_CH{IN_VALID}};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
            cond_ok_q   <= '0;
        end else begin
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            cond_ok_q   <= cond_ok_d;
        end
    end

    assign FLAGS     = flags_q;
    assign OUT_VALID = out_valid_q;
    assign COND_OK   = cond_ok_q;

endmodule

// File: doc/cond_eval_unit.md
Name: cond_eval_unit

Overview:
- Registered, multi-channel ARM condition-evaluation stage with its own NZCV status-flag register.
- Holds the architectural flags and accepts flag writebacks from the ALU (S-bit instructions).
- Evaluates NUM_CH 4-bit condition fields per cycle against the current flags, with optional same-cycle bypass.
- Presents registered pass/fail results to the execute/writeback control, with stall and flush support.

Parameters:
- NUM_CH, 2, number of independent condition channels evaluated per cycle (1..4).
- BYPASS, 1, 1: evaluation uses FLAG_IN when FLAG_WE is high in the same cycle; 0: evaluation always uses the flag register.
- NV_MODE, 0, result for code 4'b1111: 0 gives false (never); 1 gives true (unconditional space).

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- FLAG_WE  in  1  flag-register write enable (S-bit result valid)
- FLAG_IN  in  4  new flags {N,Z,C,V}, bit3 = N
- IN_VALID  in  1  COND bus carries a valid instruction group
- COND  in  4*NUM_CH  condition codes; channel i at [4i+3:4i]
- HOLD  in  1  stall: output stage keeps its value
- FLUSH  in  1  kill the in-flight and incoming group
- OUT_VALID  out  1  registered valid for COND_OK
- COND_OK  out  NUM_CH  registered pass (1) / fail (0) per channel
- FLAGS  out  4  current flag register {N,Z,C,V}

Behaviour:
- Reset values: FLAGS=4'b0000, OUT_VALID=0, COND_OK=0, applied asynchronously while RST_N=0.
- Reset deasserted mid-operation: the first edge after release behaves as normal; no residue from the pre-reset group survives.
- Flag register:
  - On each rising edge with FLAG_WE=1, FLAGS <= FLAG_IN.
  - FLAGS updates regardless of HOLD and FLUSH.
- Effective flags: EFF = (BYPASS && FLAG_WE) ? FLAG_IN : FLAGS.
- Condition table (per channel, on EFF):
  - 0000 EQ: Z.  0001 NE: !Z.  0010 CS: C.  0011 CC: !C.
  - 0100 MI: N.  0101 PL: !N.  0110 VS: V.  0111 VC: !V.
  - 1000 HI: C&!Z.  1001 LS: !C|Z.  1010 GE: N==V.  1011 LT: N!=V.
  - 1100 GT: !Z&(N==V).  1101 LE: Z|(N!=V).  1110 AL: 1.  1111: NV_MODE.
- Output stage, latency 1 edge, with priority FLUSH > HOLD > normal:
  - FLUSH=1: OUT_VALID <= 0 and COND_OK <= 0.
  - HOLD=1 (FLUSH=0): OUT_VALID and COND_OK keep their values. The incoming group is not captured; upstream must hold it.
  - Normal: OUT_VALID <= IN_VALID; COND_OK[i] <= IN_VALID & eval(COND_i, EFF).
- COND_OK is always 0 when OUT_VALID is 0.
- Channels are independent; all channels share the same EFF.
- HOLD does not freeze evaluation flags. A group released after a stall is evaluated against the flags at its capture edge.

Decomposition:
- Shared package cond_pkg holds:
  - localparams COND_EQ..COND_NV (4-bit);
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural sub-module, cond_decode:
  - combinational, inputs cond[3:0], flags[3:0], nv_mode, output ok;
  - instantiated NUM_CH times via generate.
- The top level contains the flag register, the bypass mux and the output stage.

Test Plan:
- Reset: hold RST_N=0 with IN_VALID=1, COND=8'hEE -> FLAGS=0, OUT_VALID=0, COND_OK=2'b00; release, next edge -> OUT_VALID=1, COND_OK=2'b11.
- Exhaustive table: sweep all 16 flags x 16 codes with BYPASS=0, NV_MODE=0; compare against a reference model. Sample point: FLAGS=4'b0100 (Z), COND ch0=0000, ch1=0001 -> COND_OK=2'b01.
- Bypass, FLAGS=0:
  - BYPASS=1: FLAG_WE=1, FLAG_IN=4'b0100, COND ch0=EQ, same cycle -> COND_OK[0]=1 next edge, FLAGS=4'b0100.
  - BYPASS=0: same stimulus -> COND_OK[0]=0.
- Signed compare: FLAG_IN=4'b1001 (N=1,V=1,Z=0), COND ch0=GT(1100), ch1=LT(1011) -> COND_OK=2'b01. Then flags 4'b1000 -> 2'b10.
- HOLD/FLUSH: capture group (OUT_VALID=1, COND_OK=2'b10), assert HOLD 3 cycles while COND changes -> outputs stay 2'b10. Assert HOLD+FLUSH together -> OUT_VALID=0, COND_OK=0 next edge.
- NV code: COND=8'hFF, IN_VALID=1 -> COND_OK=2'b00 with NV_MODE=0, 2'b11 with NV_MODE=1; FLAG_WE during FLUSH still updates FLAGS.
